// File: rtl/bit_stuffer_if.sv
// Handshake bundle between an upstream bit source and the bit stuffer.
// The slave side is the stuffer; the master side drives unstuffed bits.
interface bit_stuffer_if;
    logic bstr_in;
    logic bstr_in_avail;
    logic in_done;
    logic in_stall;
    logic bstr_out;
    logic bstr_out_avail;
    logic out_done;

    modport master (
        output bstr_in,
        output bstr_in_avail,
        output in_done,
        input  in_stall,
        input  bstr_out,
        input  bstr_out_avail,
        input  out_done
    );

    modport slave (
        input  bstr_in,
        input  bstr_in_avail,
        input  in_done,
        output in_stall,
        output bstr_out,
        output bstr_out_avail,
        output out_done
    );
endinterface

// File: rtl/bit_stuffer.sv
// Serial bit stuffer: inserts a 0 after every six consecutive output 1s,
// with a one-cycle upstream stall while the stuffed bit goes out.
module bit_stuffer (
    input  logic          clk,
    input  logic          rst_b,
    bit_stuffer_if.slave  bus
);
    typedef enum logic {RUN, STUFF} state_t;

    state_t     state, state_n;
    logic [2:0] ones, ones_n;
    logic       done_pend, done_pend_n;
    logic       out_q, out_n;
    logic       avail_q, avail_n;
    logic       done_q, done_n;

    assign bus.in_stall       = (state == STUFF);
    assign bus.bstr_out       = out_q;
    assign bus.bstr_out_avail = avail_q;
    assign bus.out_done       = done_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= RUN;
            ones      <= '0;
            done_pend <= 1'b0;
            out_q     <= 1'b0;
            avail_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            ones      <= ones_n;
            done_pend <= done_pend_n;
            out_q     <= out_n;
            avail_q   <= avail_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        ones_n      = ones;
        done_pend_n = done_pend;
        out_n       = 1'b0;
        avail_n     = 1'b0;
        done_n      = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.bstr_in_avail) begin
                    out_n   = bus.bstr_in;
                    avail_n = 1'b1;
                    if (bus.bstr_in && ones == 3'd5) begin
                        // Sixth 1: the packet end, if any, rides on the stuffed 0.
                        ones_n      = 3'd6;
                        state_n     = STUFF;
                        done_pend_n = bus.in_done;
                    end else if (bus.in_done) begin
                        ones_n = '0;
                        done_n = 1'b1;
                    end else if (bus.bstr_in) begin
                        ones_n = ones + 3'd1;
                    end else begin
                        ones_n = '0;
                    end
                end else begin
                    ones_n = '0;
                end
            end
            STUFF: begin
                out_n       = 1'b0;
                avail_n     = 1'b1;
                done_n      = done_pend;
                done_pend_n = 1'b0;
                ones_n      = '0;
                state_n     = RUN;
            end
            default: state_n = RUN;
        endcase
    end
endmodule

// File: doc/bit_stuffer.md
BIT_STUFFER -- requirements
Module: bit_stuffer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_b  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 bstr_in  input  1  unstuffed transmit data bit.
REQ-005 bstr_in_avail  input  1  bstr_in is valid this cycle.
REQ-006 in_done  input  1  marks bstr_in as the last packet bit; meaningful only with bstr_in_avail=1.
REQ-007 in_stall  output  1  block is not accepting input this cycle; upstream holds bstr_in, bstr_in_avail and in_done stable.
REQ-008 bstr_out  output  1  stuffed data bit, registered.
REQ-009 bstr_out_avail  output  1  bstr_out valid this cycle, registered.
REQ-010 out_done  output  1  one-cycle pulse marking the final output bit of a packet, registered.

Function
REQ-011 The FSM SHALL have two states, RUN and STUFF, plus a 3-bit ones counter (range 0..6, never exceeds 6) and a done_pend flag.
REQ-012 in_stall SHALL equal (state == STUFF), decoded combinationally from the state register only.
REQ-013 An input bit is accepted on a clock edge when bstr_in_avail=1 and in_stall=0.
REQ-014 On acceptance, bstr_out SHALL take bstr_in and bstr_out_avail SHALL be 1 on the next cycle (latency 1 cycle).
REQ-015 On acceptance, the counter SHALL increment if bstr_in=1 and clear to 0 if bstr_in=0.
REQ-016 In RUN with bstr_in_avail=0, bstr_out_avail SHALL be 0 next cycle and the counter SHALL clear to 0 (gaps break a run, matching receiver behaviour).
REQ-017 When an accepted 1 brings the counter to 6, the state SHALL go to STUFF on the same edge.
REQ-018 In STUFF, on the next edge, bstr_out SHALL be 0 with bstr_out_avail=1, the counter SHALL clear to 0 and the state SHALL return to RUN; no input is accepted in that cycle.
REQ-019 Exactly one 0 SHALL be inserted after every six consecutive output 1s, and no 0 SHALL be inserted otherwise.
REQ-020 A data 0 that follows six 1s SHALL still be sent after the stuffed 0 (the stuffed bit is never merged with data).
REQ-021 If in_done is accepted with a bit that does not enter STUFF, out_done SHALL be 1 in the same cycle as that bit's output.
REQ-022 If in_done is accepted with the bit that enters STUFF, done_pend SHALL be set and out_done SHALL instead be 1 with the stuffed 0; done_pend then clears.
REQ-023 After out_done, the counter SHALL be 0 so the next packet starts a fresh run.
REQ-024 out_done SHALL be 0 in every other cycle; in_done with bstr_in_avail=0 SHALL be ignored.

Reset
REQ-025 When rst_b=0 at a clock edge: state=RUN, counter=0, done_pend=0, bstr_out=0, bstr_out_avail=0, out_done=0; in_stall is therefore 0 on the following cycle.
REQ-026 A reset in STUFF SHALL discard the pending stuffed bit and any pending out_done.
REQ-027 Reset SHALL take priority over all other events on the same edge.

Verification
REQ-028 Input bits 0,1,1,1,1,1,1,0 with avail held high -> output 0,1,1,1,1,1,1,0(stuff),0 one cycle late; in_stall high for exactly one cycle, the cycle after the sixth 1 is accepted.
REQ-029 Twelve consecutive 1s -> output 111111 0 111111 0; two stall cycles; counter never exceeds 6.
REQ-030 Five 1s, avail low for 1 cycle, then two 1s -> no stuffed bit; bstr_out_avail=0 for the gap cycle.
REQ-031 Six 1s with in_done on the sixth -> out_done=0 with the sixth 1 and out_done=1 with the following stuffed 0; seven bits total.
REQ-032 rst_b=0 during the STUFF cycle -> next cycle bstr_out_avail=0, out_done=0, in_stall=0; a following run of six 1s is stuffed normally.
REQ-033 in_done on a 0 after three 1s -> out_done=1 with that 0; the next packet's first six 1s are stuffed after the sixth 1, not earlier.
